key_conditioner: RTL

Front-end conditioner for the board push-buttons that drive the memory's `ensure` strobe and similar command inputs. It synchronises raw mechanical keys into the `clock` domain, debounces each key independently, and produces clean single-cycle press/release pulses plus optional auto-repeat pulses while a key is held. Each `key_press[i]` pulse is suitable for a one-cycle write/read enable to the downstream storage stage.

---
 rtl/key_conditioner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises raw push-button inputs into the clock domain,
// debounces each key independently and turns accepted level changes into
// single-cycle press / release pulses, plus optional auto-repeat pulses while
// a key stays held. Every output is a flop; nothing combinational reaches the
// ports from key_raw.
module key_conditioner #(
  parameter int unsigned keys            = 2,
  parameter bit          pressed_level   = 1'b1,
  parameter int unsigned debounce_cycles = 500000,
  parameter int unsigned hold_cycles     = 25000000,
  parameter int unsigned repeat_cycles   = 5000000
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [keys-1:0] key_raw,
  output logic [keys-1:0] key_level,
  output logic [keys-1:0] key_press,
  output logic [keys-1:0] key_release,
  output logic [keys-1:0] key_repeat
);

  // Auto-repeat is switched off entirely when the hold time is zero; the hold
  // counter then never moves, so its width only needs to cover one count.
  localparam bit          REPEAT_EN = (hold_cycles != 0);
  localparam int unsigned HOLD_MAX  = !REPEAT_EN ? 1 :
                                      ((hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles);

  // Counters are sized to hold exactly their terminal value.
  localparam int DB_W   = (debounce_cycles < 2) ? 1 : $clog2(debounce_cycles + 1);
  localparam int HOLD_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

  // A counter that is about to reach its terminal value fires instead of
  // incrementing, which is why these constants are "terminal minus one".
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'((debounce_cycles == 0) ? 0 : debounce_cycles - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_EN ? hold_cycles - 1 : 0);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((repeat_cycles == 0) ? 0 : repeat_cycles - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REPEAT   = 2'd2
  } key_state_e;

  for (genvar i = 0; i < keys; i++) begin : g_key

    logic              raw_pressed;
    logic              s1;
    logic              s2;
    logic              level_q;
    logic [DB_W-1:0]   db_count;
    logic              db_expire;
    logic              accept_press;
    logic              accept_release;

    key_state_e        state_q;
    key_state_e        state_d;
    logic [HOLD_W-1:0] hold_count_q;
    logic [HOLD_W-1:0] hold_count_d;
    logic              press_q;
    logic              press_d;
    logic              release_q;
    logic              release_d;
    logic              repeat_q;
    logic              repeat_d;

    // Normalise polarity up front so everything downstream reads 1 = pressed.
    assign raw_pressed = (key_raw[i] == pressed_level);

    // Two-flop synchroniser; the raw pin is never looked at anywhere else.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw_pressed;
        s2 <= s1;
      end
    end

    // The debounce run completes on the sample that would bring the count to
    // its terminal value; the FSM sees that as an accepted press or release.
    assign db_expire      = (s2 != level_q) && (db_count == DB_LAST);
    assign accept_press   = db_expire && s2;
    assign accept_release = db_expire && !s2;

    // Count consecutive samples disagreeing with the accepted level; any
    // agreeing sample restarts the run, so short glitches never get through.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        db_count <= '0;
        level_q  <= 1'b0;
      end else if (s2 == level_q) begin
        db_count <= '0;
      end else if (db_expire) begin
        db_count <= '0;
        level_q  <= s2;
      end else begin
        db_count <= db_count + 1'b1;
      end
    end

    // Key FSM state, hold/repeat counter and the registered event pulses.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        state_q      <= ST_RELEASED;
        hold_count_q <= '0;
        press_q      <= 1'b0;
        release_q    <= 1'b0;
        repeat_q     <= 1'b0;
      end else begin
        state_q      <= state_d;
        hold_count_q <= hold_count_d;
        press_q      <= press_d;
        release_q    <= release_d;
        repeat_q     <= repeat_d;
      end
    end

    // Next-state logic: a release always wins over a repeat that would expire
    // in the same cycle, which keeps the three pulses mutually exclusive.
    always_comb begin
      state_d      = state_q;
      hold_count_d = hold_count_q;
      press_d      = 1'b0;
      release_d    = 1'b0;
      repeat_d     = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (accept_press) begin
            press_d      = 1'b1;
            hold_count_d = '0;
            state_d      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept_release) begin
            release_d    = 1'b1;
            hold_count_d = '0;
            state_d      = ST_RELEASED;
          end else if (REPEAT_EN) begin
            if (hold_count_q == HOLD_LAST) begin
              repeat_d     = 1'b1;
              hold_count_d = '0;
              state_d      = ST_REPEAT;
            end else begin
              hold_count_d = hold_count_q + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (accept_release) begin
            release_d    = 1'b1;
            hold_count_d = '0;
            state_d      = ST_RELEASED;
          end else if (hold_count_q == REP_LAST) begin
            repeat_d     = 1'b1;
            hold_count_d = '0;
          end else begin
            hold_count_d = hold_count_q + 1'b1;
          end
        end
        default: begin
          hold_count_d = '0;
          state_d      = ST_RELEASED;
        end
      endcase
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_repeat[i]  = repeat_q;

  end

endmodule
